// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent flip-flops with run-time SR/JK/D/T mode, synchronous overrides and sticky error flags.
// Optional saturating change counter on evt_cnt is enabled by defining FF_EVT_CNT_EN.
module sr_ff_bank #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   INIT  = '0,
  parameter int                 CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s_n,
  input  logic [WIDTH-1:0] r_n,
  input  logic [WIDTH-1:0] pre_n,
  input  logic [WIDTH-1:0] clr_n,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] err_set;

  assign mode_sel = mode_e'(mode);

  // Priority per bit: clear, preset, enable-hold, then the mode function.
  always_comb begin
    q_next  = q;
    err_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!clr_n[i]) begin
        q_next[i]  = 1'b0;
        err_set[i] = ~pre_n[i];
      end else if (!pre_n[i]) begin
        q_next[i] = 1'b1;
      end else if (en) begin
        unique case (mode_sel)
          MODE_SR: begin
            unique case ({~s_n[i], ~r_n[i]})
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              2'b11:   err_set[i] = 1'b1;
              default: q_next[i] = q[i];
            endcase
          end
          MODE_JK: begin
            unique case ({~s_n[i], ~r_n[i]})
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              2'b11:   q_next[i] = ~q[i];
              default: q_next[i] = q[i];
            endcase
          end
          MODE_D:  q_next[i] = ~s_n[i];
          MODE_T:  q_next[i] = q[i] ^ ~s_n[i];
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= INIT;
      err <= '0;
    end else begin
      q   <= q_next;
      err <= (err_clr ? '0 : err) | err_set;
    end
  end

  assign qb = ~q;

`ifdef FF_EVT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (err_clr) begin
      evt_cnt <= '0;
    end else if ((q_next != q) && (evt_cnt != {CNT_W{1'b1}})) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank (WIDTH=8, INIT=8'hA5, CNT_W=4).
module tb_sr_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] s_n;
  logic [7:0] r_n;
  logic [7:0] pre_n;
  logic [7:0] clr_n;
  logic       err_clr;
  logic [7:0] q;
  logic [7:0] qb;
  logic [7:0] err;
  logic [3:0] evt_cnt;

  int checks   = 0;
  int failures = 0;

  sr_ff_bank #(.WIDTH(8), .INIT(8'hA5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .s_n(s_n), .r_n(r_n), .pre_n(pre_n), .clr_n(clr_n),
    .err_clr(err_clr), .q(q), .qb(qb), .err(err), .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input logic [7:0] r,
                               input logic [7:0] p, input logic [7:0] c,
                               input logic e, input logic ec);
    mode = m; s_n = s; r_n = r; pre_n = p; clr_n = c; en = e; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode = 2'd0; s_n = 8'hFF; r_n = 8'hFF;
    pre_n = 8'hFF; clr_n = 8'hFF; err_clr = 1'b0;

    #3 rst = 1'b1;
    #1;
    checkOutput("reset_q", q, 8'hA5);
    checkOutput("reset_qb", qb, 8'h5A);
    checkOutput("reset_err", err, 8'h00);
    checkOutput("reset_cnt", evt_cnt, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'd0, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("sr_set_b0", q, 8'hA5);
    applyStimulus(2'd0, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("sr_reset_b0", q, 8'hA4);
    checkOutput("sr_reset_qb", qb, 8'h5B);

    applyStimulus(2'd0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("sr_forbid_q", q, 8'hA4);
    checkOutput("sr_forbid_err", err, 8'hFF);
    applyStimulus(2'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("err_clr", err, 8'h00);
    checkOutput("err_clr_q", q, 8'hA4);

    applyStimulus(2'd0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0);
    applyStimulus(2'd0, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("err_clr_vs_new", err, 8'h01);

    applyStimulus(2'd0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    checkOutput("clear_all", q, 8'h00);

    applyStimulus(2'd1, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("jk_toggle1", q, 8'hF0);
    applyStimulus(2'd1, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("jk_toggle2", q, 8'h00);
    checkOutput("jk_no_err", err, 8'h01);

    applyStimulus(2'd3, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("t_toggle1", q, 8'h01);
    applyStimulus(2'd3, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("t_toggle2", q, 8'h00);
    applyStimulus(2'd3, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("t_toggle3", q, 8'h01);

    // Clear counter while holding, then 20 toggles of bit0; counter should saturate at 15.
    applyStimulus(2'd3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("cnt_cleared", evt_cnt, 4'd0);
    for (int n = 0; n < 20; n++)
      applyStimulus(2'd3, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("t_after20", q, 8'h01);
`ifdef FF_EVT_CNT_EN
    checkOutput("cnt_saturate", evt_cnt, 4'd15);
`else
    checkOutput("cnt_tied0", evt_cnt, 4'd0);
`endif
    applyStimulus(2'd3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("cnt_errclr", evt_cnt, 4'd0);
    checkOutput("err_after_clr", err, 8'h00);

    applyStimulus(2'd2, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    checkOutput("en0_hold", q, 8'h01);
    applyStimulus(2'd2, 8'h00, 8'hFF, 8'h7F, 8'hFF, 1'b0, 1'b0);
    checkOutput("preset_b7", q, 8'h81);
    applyStimulus(2'd2, 8'h00, 8'hFF, 8'h7F, 8'h7F, 1'b0, 1'b0);
    checkOutput("pre_clr_q", q, 8'h01);
    checkOutput("pre_clr_err", err, 8'h80);

    applyStimulus(2'd2, 8'h3C, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("d_q1", q, 8'hC3);
    checkOutput("d_qb1", qb, 8'h3C);
    applyStimulus(2'd2, 8'hC3, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("d_q2", q, 8'h3C);
    checkOutput("d_qb2", qb, 8'hC3);

    #3 rst = 1'b1;
    #1;
    checkOutput("midreset_q", q, 8'hA5);
    checkOutput("midreset_qb", qb, 8'h5A);
    checkOutput("midreset_err", err, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("post_reset_hold", q, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Clocked, parametrised bank of WIDTH independent storage bits.
- Each bit behaves as an SR, JK, D or T flip-flop, chosen by a run-time mode input.
- Keeps the active-low set/reset input convention of the existing SR latch cells.
- Adds synchronous preset/clear overrides, illegal-input detection with sticky flags, and a guaranteed-complementary q/qb pair.
- Used as the general storage primitive in the flip-flop development set, replacing hand-wired latch pairs.

Parameters:
- WIDTH, 8, number of storage bits (1..64).
- INIT, '0 (WIDTH bits), value loaded into q on reset.
- CNT_W, 8, width of the optional event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  synchronous enable; when 0, q holds (overrides still apply).
- mode  input  2  0=SR, 1=JK, 2=D, 3=T; global to all bits.
- s_n  input  WIDTH  active-low set / J / D / T input per bit.
- r_n  input  WIDTH  active-low reset / K input per bit; ignored in D and T modes.
- pre_n  input  WIDTH  active-low synchronous preset per bit.
- clr_n  input  WIDTH  active-low synchronous clear per bit.
- err_clr  input  1  synchronous pulse; clears all sticky error flags.
- q  output  WIDTH  stored state.
- qb  output  WIDTH  always exactly ~q, including during reset.
- err  output  WIDTH  sticky per-bit illegal-input flag.
- evt_cnt  output  CNT_W  saturating change counter (optional feature).

Behaviour:
- Reset (async, rst=1):
  - q=INIT, qb=~INIT, err=0, evt_cnt=0.
  - Takes effect immediately, mid-cycle, and overrides everything.
- Definitions: j=~s_n[i], k=~r_n[i], p=~pre_n[i], c=~clr_n[i].
- Per-bit next-state priority at each rising clk edge:
  1. c=1 -> q=0. If p=1 at the same time, q=0 (clear wins) and err[i] is set.
  2. p=1 -> q=1.
  3. en=0 -> hold.
  4. Mode function:
     - SR: j=1,k=0 -> 1; j=0,k=1 -> 0; j=0,k=0 -> hold; j=1,k=1 -> hold and set err[i]. This is the forbidden input and never causes memory loss.
     - JK: as SR, except j=1,k=1 -> q toggles (no error).
     - D: q=j.
     - T: j=1 -> toggle; j=0 -> hold.
- Overrides apply regardless of en and mode.
- Latency: one clock from input to q. qb is combinational ~q, with no extra register.
- Error flags:
  - err[i] is set on the edge where the illegal condition is sampled.
  - err_clr=1 clears all flags on that edge.
  - If err_clr and a new illegal condition occur on the same edge, the new condition wins and the flag stays 1.
- Mode changes take effect on the first edge after mode is sampled; there is no mode-change state.
- All bits are fully independent; no cross-bit interaction except the shared en, mode and err_clr.

Optional Feature:
- Macro: FF_EVT_CNT_EN.
- Defined:
  - evt_cnt increments by 1 on each edge where q changes in at least one bit.
  - Saturates at 2^CNT_W-1.
  - Cleared by rst and by err_clr.
- Undefined: evt_cnt is tied to 0, no counter logic is generated, and the port list is unchanged.

Test Plan:
- Reset and SR mode:
  - WIDTH=8, INIT=8'hA5, assert rst mid-cycle -> q=8'hA5 and qb=8'h5A immediately.
  - Release rst, mode=0, s_n=8'hFE, r_n=8'hFF -> after 1 edge q=8'hA5 (bit0 already 1).
  - Then s_n=8'hFF, r_n=8'hFE -> q=8'hA4.
- SR forbidden input: mode=0, s_n=r_n=8'h00 for one edge from q=8'hA4 -> q stays 8'hA4 and err=8'hFF.
  - Next edge err_clr=1 with s_n=r_n=8'hFF -> err=8'h00.
- JK and T toggling:
  - mode=1, s_n=r_n=8'h0F from q=8'h00 -> q=8'hF0 after 1 edge, 8'h00 after 2.
  - mode=3, s_n=8'hFE -> q[0] alternates 1,0,1 on successive edges.
- Overrides:
  - en=0, mode=2, s_n=8'h00 -> q holds.
  - pre_n=8'h7F -> q[7]=1.
  - pre_n=8'h7F and clr_n=8'h7F on the same edge -> q[7]=0 and err[7]=1.
- D mode: mode=2, en=1, s_n driven 8'h3C then 8'hC3 on consecutive edges -> q follows 8'hC3 then 8'h3C with 1-cycle latency; qb=~q checked every cycle.
- FF_EVT_CNT_EN defined, CNT_W=4: toggle bit0 in T mode for 20 edges -> evt_cnt reaches 15 and holds.
  - err_clr -> evt_cnt=0.
  - With the macro undefined, evt_cnt stays 0 throughout.
